// File: rtl/piso_serializer.sv
// -----------------------------------------------------------------------------
// piso_serializer
//
// Parallel-in, serial-out stage that feeds a serial 1101 sequence detector.
// A WIDTH-bit word is accepted through a valid/ready handshake and then
// emitted one bit per clock on x_out. A new word can be accepted in the same
// cycle as the last bit of the previous word. This keeps the serial stream
// contiguous across word boundaries, so patterns that straddle two words are
// still seen by the detector.
//
// Parameters:
//   WIDTH      word size in bits (WIDTH >= 2)
//   MSB_FIRST  1: din[WIDTH-1] leaves first, 0: din[0] leaves first
//   IDLE_LEVEL level driven on x_out while no word is in flight
//
// Ports:
//   clk         rising-edge clock
//   reset       synchronous, active-high reset
//   din         parallel word, sampled only on an accepted handshake
//   load_valid  producer has a word on din
//   load_ready  a word can be accepted this cycle (combinational)
//   x_out       serial data bit (registered), drives the detector's x
//   bit_valid   x_out carries a data bit this cycle (registered)
//   done        one-cycle pulse alongside the last bit of a word (registered)
// -----------------------------------------------------------------------------
module piso_serializer #(
  parameter int WIDTH      = 8,
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             x_out,
  output logic             bit_valid,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;       // index of the bit currently on x_out
  logic [WIDTH-1:0] shreg_q, shreg_d;   // bits still waiting to go out
  logic             x_q, x_d;
  logic             bv_q, bv_d;
  logic             done_q, done_d;

  logic             last_bit;
  logic             accept;

  // Bit-order dependent taps. "head" is the bit that goes onto x_out next;
  // "tail" is what remains in the shift register once the head has left.
  logic             load_head;
  logic [WIDTH-1:0] load_tail;
  logic             shift_head;
  logic [WIDTH-1:0] shift_tail;

  generate
    if (MSB_FIRST) begin : g_msb_first
      assign load_head  = din[WIDTH-1];
      assign load_tail  = {din[WIDTH-2:0], 1'b0};
      assign shift_head = shreg_q[WIDTH-1];
      assign shift_tail = {shreg_q[WIDTH-2:0], 1'b0};
    end else begin : g_lsb_first
      assign load_head  = din[0];
      assign load_tail  = {1'b0, din[WIDTH-1:1]};
      assign shift_head = shreg_q[0];
      assign shift_tail = {1'b0, shreg_q[WIDTH-1:1]};
    end
  endgenerate

  // Ready is also high during the final bit so the next word can be
  // chained with no idle cycle in between.
  assign last_bit   = (state_q == S_SHIFT) && (cnt_q == LAST_IDX);
  assign load_ready = (state_q == S_IDLE) || last_bit;
  assign accept     = load_valid && load_ready;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    x_d     = x_q;
    bv_d    = bv_q;
    done_d  = 1'b0;

    if (accept) begin
      // The first bit is registered straight onto x_out at the accepting
      // edge. The rest of the word is parked in the shift register.
      state_d = S_SHIFT;
      cnt_d   = '0;
      shreg_d = load_tail;
      x_d     = load_head;
      bv_d    = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          x_d  = IDLE_LEVEL;
          bv_d = 1'b0;
        end
        S_SHIFT: begin
          if (last_bit) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            shreg_d = '0;
            x_d     = IDLE_LEVEL;
            bv_d    = 1'b0;
          end else begin
            cnt_d   = cnt_q + CW'(1);
            shreg_d = shift_tail;
            x_d     = shift_head;
            bv_d    = 1'b1;
            // done is registered, so raise it on the edge that brings the
            // final bit onto x_out.
            done_d  = (cnt_q + CW'(1)) == LAST_IDX;
          end
        end
        default: begin
          state_d = S_IDLE;
          x_d     = IDLE_LEVEL;
          bv_d    = 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // State registers. Reset takes priority over a same-edge accept, so a word
  // offered during reset is dropped.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      shreg_q <= '0;
      x_q     <= IDLE_LEVEL;
      bv_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      x_q     <= x_d;
      bv_q    <= bv_d;
      done_q  <= done_d;
    end
  end

  assign x_out     = x_q;
  assign bit_valid = bv_q;
  assign done      = done_q;

endmodule

// File: tb/tb_piso_serializer.sv
// -----------------------------------------------------------------------------
// Testbench for piso_serializer.
//
// Two instances share one set of inputs: u_msb (MSB_FIRST=1) and u_lsb
// (MSB_FIRST=0). The bench applies a table of directed vectors, then a few
// hand-written multi-cycle sequences. It finishes with a randomized run that
// is checked against a queue-based stream model.
// -----------------------------------------------------------------------------
module tb_piso_serializer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] din;
  logic         load_valid;

  logic m_ready, m_x, m_bv, m_done;
  logic l_ready, l_x, l_bv, l_done;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u_msb (
    .clk        (clk),
    .reset      (reset),
    .din        (din),
    .load_valid (load_valid),
    .load_ready (m_ready),
    .x_out      (m_x),
    .bit_valid  (m_bv),
    .done       (m_done)
  );

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) u_lsb (
    .clk        (clk),
    .reset      (reset),
    .din        (din),
    .load_valid (load_valid),
    .load_ready (l_ready),
    .x_out      (l_x),
    .bit_valid  (l_bv),
    .done       (l_done)
  );

  // One directed vector: inputs applied before an edge, outputs expected
  // right after that edge.
  typedef struct {
    logic         rst;
    logic         lv;
    logic [W-1:0] d;
    logic         x;
    logic         bv;
    logic         dn;
    logic         rdy;
  } vec_t;

  vec_t vt[$];

  task automatic add(input logic rst, input logic lv, input logic [W-1:0] d,
                     input logic x, input logic bv, input logic dn, input logic rdy);
    vec_t v;
    v.rst = rst; v.lv = lv; v.d = d; v.x = x; v.bv = bv; v.dn = dn; v.rdy = rdy;
    vt.push_back(v);
  endtask

  task automatic chk(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Drive inputs, advance one edge, then settle past the edge.
  task automatic cyc(input logic r, input logic lv, input logic [W-1:0] d);
    reset = r; load_valid = lv; din = d;
    @(posedge clk);
    #1;
  endtask

  // Add the eight data-bit rows of a word, MSB first. The first row carries
  // the accept itself; done and ready are expected on the last row only.
  task automatic add_word_rows(input logic [W-1:0] w);
    for (int i = 0; i < W; i++) begin
      add(1'b0, (i == 0), w, w[W-1-i], 1'b1, (i == W-1), (i == W-1));
    end
  endtask

  // Reference model: a queue of bits still to appear on x_out. The head is
  // the bit shown in the current cycle.
  bit qm[$];
  bit ql[$];

  task automatic model_edge(input logic r, input logic acc, input logic [W-1:0] d);
    if (r) begin
      qm.delete();
      ql.delete();
    end else begin
      if (qm.size() > 0) void'(qm.pop_front());
      if (ql.size() > 0) void'(ql.pop_front());
      if (acc) begin
        for (int i = W-1; i >= 0; i--) qm.push_back(d[i]);
        for (int i = 0; i < W; i++)    ql.push_back(d[i]);
      end
    end
  endtask

  initial begin
    logic [15:0] stream;
    logic [15:0] y_exp;
    logic [3:0]  win;
    logic        y_got;
    logic [W-1:0] w_lsb;

    reset = 1'b1; load_valid = 1'b0; din = '0;

    // ---------------- table-driven vectors (MSB-first instance) ------------
    add(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);   // reset state
    add_word_rows(8'hD0);                              // single word
    add(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);   // back to idle
    add_word_rows(8'h0D);                              // back-to-back pair
    add_word_rows(8'hA5);
    add(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    // Load while busy: 8'hFF is offered at bit indices 3 and 4 of 8'h00.
    add(1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);   // idx0
    add(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);   // idx1
    add(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);   // idx2
    add(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);   // idx3
    add(1'b0, 1'b1, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b0);   // idx4, ignored
    add(1'b0, 1'b1, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b0);   // idx5, ignored
    add(1'b0, 1'b0, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b0);   // idx6
    add(1'b0, 1'b0, 8'hFF, 1'b0, 1'b1, 1'b1, 1'b1);   // idx7
    add(1'b0, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1);   // idle, FF not sent

    for (int i = 0; i < vt.size(); i++) begin
      cyc(vt[i].rst, vt[i].lv, vt[i].d);
      chk($sformatf("vec%0d x_out", i),      m_x,     vt[i].x);
      chk($sformatf("vec%0d bit_valid", i),  m_bv,    vt[i].bv);
      chk($sformatf("vec%0d done", i),       m_done,  vt[i].dn);
      chk($sformatf("vec%0d load_ready", i), m_ready, vt[i].rdy);
      $display("vec %0d: rst=%b lv=%b din=%h -> x=%b bv=%b done=%b rdy=%b",
               i, vt[i].rst, vt[i].lv, vt[i].d, m_x, m_bv, m_done, m_ready);
    end

    // ---------------- reset mid-word ---------------------------------------
    cyc(1'b1, 1'b0, 8'h00);
    cyc(1'b0, 1'b1, 8'hD0);
    cyc(1'b0, 1'b0, 8'hD0);
    cyc(1'b0, 1'b0, 8'hD0);
    chk("midrst third bit", m_x, 1'b0);
    cyc(1'b1, 1'b0, 8'hD0);
    chk("midrst x_out",      m_x,     1'b0);
    chk("midrst bit_valid",  m_bv,    1'b0);
    chk("midrst done",       m_done,  1'b0);
    chk("midrst load_ready", m_ready, 1'b1);
    cyc(1'b0, 1'b0, 8'hD0);
    chk("midrst no 4th bit", m_bv, 1'b0);
    $display("seq reset-mid-word: x=%b bv=%b", m_x, m_bv);

    // Reset wins over a same-edge accept; the next edge may accept.
    cyc(1'b1, 1'b1, 8'hFF);
    chk("rst prio bit_valid", m_bv, 1'b0);
    cyc(1'b0, 1'b1, 8'h80);
    chk("post-rst accept x",  m_x,  1'b1);
    chk("post-rst accept bv", m_bv, 1'b1);
    for (int i = 1; i < W; i++) cyc(1'b0, 1'b0, 8'h00);
    cyc(1'b0, 1'b0, 8'h00);
    $display("seq reset-priority: bv=%b", m_bv);

    // ---------------- LSB-first instance, din=8'h0B ------------------------
    cyc(1'b1, 1'b0, 8'h00);
    w_lsb = 8'hD0;   // expected serial order 1,1,0,1,0,0,0,0 read MSB->LSB
    for (int i = 0; i < W; i++) begin
      cyc(1'b0, (i == 0), 8'h0B);
      chk($sformatf("lsb bit%0d x_out", i), l_x,    w_lsb[W-1-i]);
      chk($sformatf("lsb bit%0d done", i),  l_done, (i == W-1));
      chk($sformatf("lsb bit%0d bv", i),    l_bv,   1'b1);
    end
    cyc(1'b0, 1'b0, 8'h00);
    chk("lsb idle bv", l_bv, 1'b0);
    $display("seq lsb-first 0B: done");

    // ---------------- stream into a 1101 detector --------------------------
    cyc(1'b1, 1'b0, 8'h00);
    stream = '0;
    for (int i = 0; i < 2*W; i++) begin
      if (i < W) cyc(1'b0, (i == 0), 8'h6D);
      else       cyc(1'b0, (i == W), 8'h0D);
      chk($sformatf("det stream bv%0d", i), m_bv, 1'b1);
      stream[2*W-1-i] = m_x;
    end
    chk("det stream value", (stream == 16'h6D0D), 1'b1);
    // Overlapping 1101 hits land on bit-times 5, 8 and 16 (1-based).
    y_exp = 16'b0000_1001_0000_0001;
    win = '0;
    for (int i = 0; i < 2*W; i++) begin
      win   = {win[2:0], stream[2*W-1-i]};
      y_got = (i >= 3) && (win == 4'b1101);
      chk($sformatf("det y bit%0d", i+1), y_got, y_exp[2*W-1-i]);
    end
    $display("seq detector stream=%h", stream);

    // ---------------- randomized run vs queue model -------------------------
    cyc(1'b1, 1'b0, 8'h00);
    model_edge(1'b1, 1'b0, 8'h00);
    for (int n = 0; n < 1500; n++) begin
      logic         r, lv, mrdy;
      logic [W-1:0] d;
      r    = ($urandom_range(0, 49) == 0);
      lv   = ($urandom_range(0, 3) != 0);
      d    = W'($urandom);
      mrdy = (qm.size() <= 1);
      chk($sformatf("rnd%0d load_ready msb", n), m_ready, mrdy);
      chk($sformatf("rnd%0d load_ready lsb", n), l_ready, mrdy);
      cyc(r, lv, d);
      model_edge(r, lv && mrdy, d);
      chk($sformatf("rnd%0d x msb", n),    m_x,    (qm.size() > 0) ? qm[0] : 1'b0);
      chk($sformatf("rnd%0d bv msb", n),   m_bv,   (qm.size() > 0));
      chk($sformatf("rnd%0d done msb", n), m_done, (qm.size() == 1));
      chk($sformatf("rnd%0d x lsb", n),    l_x,    (ql.size() > 0) ? ql[0] : 1'b0);
      chk($sformatf("rnd%0d bv lsb", n),   l_bv,   (ql.size() > 0));
      chk($sformatf("rnd%0d done lsb", n), l_done, (ql.size() == 1));
    end
    $display("seq random: 1500 cycles");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
- Parallel-in, serial-out stage that sits directly upstream of the 1101 sequence detector.
- Accepts WIDTH-bit words through a valid/ready handshake and drives them out one bit per clock.
- Its serial output ties straight to the detector's x input.
- Supports back-to-back words with no idle gap, so a pattern that straddles two words is still presented contiguously.

Parameters:
- WIDTH, 8, word size in bits; legal range is WIDTH >= 2.
- MSB_FIRST, 1, 1 = bit WIDTH-1 is shifted out first; 0 = bit 0 is shifted out first.
- IDLE_LEVEL, 0, value driven on x_out while no word is being shifted.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- din  input  WIDTH  parallel word; sampled only on an accepted handshake.
- load_valid  input  1  producer has a word on din.
- load_ready  output  1  block can accept a word this cycle (combinational from state and counter).
- x_out  output  1  serial bit, registered; connects to the detector's x.
- bit_valid  output  1  x_out carries a data bit this cycle, registered.
- done  output  1  one-cycle pulse coincident with the last bit of a word, registered.

Behaviour:
- Single clock domain, clk. Reset is synchronous and active-high.
- Reset (at the clk edge with reset=1):
  - state=IDLE, counter=0, shift register=0.
  - x_out=IDLE_LEVEL, bit_valid=0, done=0.
  - load_ready=1 from the first cycle after reset.
- State machine: IDLE and SHIFT. Counter width is $clog2(WIDTH); the counter holds the index of the bit currently on x_out.
- load_ready = (state==IDLE) | (state==SHIFT & counter==WIDTH-1).
- Accept = load_valid & load_ready at a rising edge. On that edge:
  - din is captured;
  - the first bit (din[WIDTH-1] if MSB_FIRST, else din[0]) is registered onto x_out;
  - bit_valid=1 and counter=0;
  - state becomes SHIFT.
- Latency: the first bit is visible in the cycle immediately after the accepting edge.
- In SHIFT, each edge advances one bit: counter+1, and the shift register shifts toward the output end.
  - bit_valid stays 1 for exactly WIDTH consecutive cycles per word.
  - done=1 only in the cycle where counter==WIDTH-1.
- Edge ending the last bit (counter==WIDTH-1):
  - if an accept occurs, the new word's first bit follows immediately: no gap, bit_valid stays 1, done drops to 0;
  - otherwise state becomes IDLE, x_out=IDLE_LEVEL, bit_valid=0, done=0.
- load_valid while load_ready=0 is ignored. din is not sampled, and the in-flight word is undisturbed.
- Producer rule: din must be stable while load_valid=1 and load_ready=0. Nothing is buffered beyond the one word in flight.
- Reset mid-word:
  - remaining bits are discarded with no done pulse;
  - the next cycle shows IDLE outputs, and a new word may be accepted at the first edge after reset deasserts.
- reset has priority over an accept at the same edge; the word is dropped.
- Every cycle with bit_valid=1 carries a fresh bit. The downstream detector samples every clock.

Test Plan:
- Reset, then present din=8'hD0 with load_valid held 1 for one cycle, MSB_FIRST=1 -> x_out=1,1,0,1,0,0,0,0 on 8 consecutive cycles; bit_valid=1 for those 8 cycles; done=1 only on the 8th; then x_out=0, bit_valid=0, load_ready=1.
- Back-to-back: 8'h0D accepted, then 8'hA5 offered during the last-bit cycle (load_ready=1 there) -> 16 contiguous bits 00001101 10100101 with no gap; done pulses on cycles 8 and 16 only.
- Load while busy: offer 8'hFF at bit index 3 of 8'h00 -> load_ready=0, 8'hFF ignored, output continues 0,0,0,0; after the word ends the block returns to IDLE with 8'hFF not sent unless re-offered.
- Reset mid-word: after 3 bits of 8'hD0, pulse reset=1 for one cycle -> next cycle x_out=0, bit_valid=0, done=0, load_ready=1; the fourth bit never appears.
- MSB_FIRST=0, din=8'h0B -> x_out=1,1,0,1,0,0,0,0; done on the 8th bit.
- Integration with the detector (detector reset released): send 8'h6D then 8'h0D back-to-back -> the detector's y goes high exactly on the bit-time of the final '1' of each 1101 occurrence in the stream 01101101 00001101.
